// File: rtl/fpnew_result_buffer.sv
// Purpose     : elastic result FIFO between an operation-group slice and the output arbiter.
// Latency     : 1 cycle push-to-head (0 cycles when FPNEW_RESULT_BUF_BYPASS_EN is defined and the buffer is empty).
// Backpressure: in_ready_o depends only on occupancy and flush_i, never combinationally on out_ready_i.
//
// Optional feature macro: FPNEW_RESULT_BUF_BYPASS_EN (empty-buffer combinational pass-through).
// Ports:
//   clk_i, rst_ni                        clock (rising edge), async active-low reset
//   result_i/status_i/extension_bit_i/   upstream entry fields
//   tag_i/aux_i, in_valid_i, in_ready_o  upstream handshake
//   flush_i                              synchronous discard of all contents
//   result_o/status_o/extension_bit_o/   head entry fields
//   tag_o/aux_o, out_valid_o, out_ready_i downstream handshake
//   fill_o                               registered occupancy
//   busy_o                               data held or arriving
module fpnew_result_buffer #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 2,
  parameter type         TagType = logic,
  parameter type         AuxType = logic
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [Width-1:0]           result_i,
  input  logic [4:0]                 status_i,
  input  logic                       extension_bit_i,
  input  TagType                     tag_i,
  input  AuxType                     aux_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic                       flush_i,
  output logic [Width-1:0]           result_o,
  output logic [4:0]                 status_o,
  output logic                       extension_bit_o,
  output TagType                     tag_o,
  output AuxType                     aux_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [$clog2(Depth+1)-1:0] fill_o,
  output logic                       busy_o
);

  localparam int unsigned CntW = $clog2(Depth + 1);
  // Depth=1 still needs a 1-bit pointer; it simply never leaves 0.
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  localparam logic [1:0] OCC_EMPTY   = 2'd0;
  localparam logic [1:0] OCC_PARTIAL = 2'd1;
  localparam logic [1:0] OCC_FULL    = 2'd2;

  typedef struct packed {
    logic [Width-1:0] result;
    logic [4:0]       status;
    logic             extension_bit;
    TagType           tag;
    AuxType           aux;
  } entry_t;

  entry_t            mem [Depth];
  entry_t            in_entry;
  entry_t            head;
  logic [PtrW-1:0]   wr_ptr_q;
  logic [PtrW-1:0]   rd_ptr_q;
  logic [CntW-1:0]   count_q;
  logic [1:0]        occ;
  logic              bypass;
  logic              push;
  logic              wr_en;
  logic              rd_en;

  // Explicit wrap so non-power-of-two depths index only valid entries.
  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign in_entry = '{result_i, status_i, extension_bit_i, tag_i, aux_i};

  always_comb begin
    occ = OCC_PARTIAL;
    if (count_q == '0)                occ = OCC_EMPTY;
    else if (count_q == CntW'(Depth)) occ = OCC_FULL;
  end

`ifdef FPNEW_RESULT_BUF_BYPASS_EN
  // Empty buffer and a consumer ready right now: hand the item straight through.
  assign bypass = (occ == OCC_EMPTY) & ~flush_i & in_valid_i & out_ready_i;
`else
  assign bypass = 1'b0;
`endif

  // A full buffer refuses input even if the head is leaving this cycle.
  assign in_ready_o  = (occ != OCC_FULL) | flush_i;
  assign out_valid_o = ((occ != OCC_EMPTY) & ~flush_i) | bypass;

  assign push  = in_valid_i & in_ready_o;
  assign wr_en = push & ~flush_i & ~bypass;
  assign rd_en = (occ != OCC_EMPTY) & ~flush_i & out_ready_i;

  assign head            = bypass ? in_entry : mem[rd_ptr_q];
  assign result_o        = head.result;
  assign status_o        = head.status;
  assign extension_bit_o = head.extension_bit;
  assign tag_o           = head.tag;
  assign aux_o           = head.aux;

  assign fill_o = count_q;
  assign busy_o = (count_q != '0) | in_valid_i;

  // Storage carries no reset; contents are only observable behind out_valid_o.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr_q] <= in_entry;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (rd_en) rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_fpnew_result_buffer.sv
module tb_fpnew_result_buffer;

  typedef logic [7:0] tag_t;
  typedef logic [3:0] aux_t;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  st;
    logic        ext;
    tag_t        tag;
    aux_t        aux;
  } item_t;

  typedef struct {
    logic        iv;
    logic [31:0] res;
    logic [4:0]  st;
    tag_t        tag;
    logic        ordy;
    logic        fl;
    logic        ov;
    logic        ir;
    logic [1:0]  fill;
    logic        busy;
    logic [31:0] eres;
    logic [4:0]  est;
    tag_t        etag;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Depth=2 instance
  logic [31:0] a_res_i, a_res_o;
  logic [4:0]  a_st_i, a_st_o;
  logic        a_ext_i, a_ext_o;
  tag_t        a_tag_i, a_tag_o;
  aux_t        a_aux_i, a_aux_o;
  logic        a_iv, a_ir, a_fl, a_ov, a_or, a_busy;
  logic [1:0]  a_fill;

  // Depth=3 instance
  logic [31:0] b_res_i, b_res_o;
  logic [4:0]  b_st_i, b_st_o;
  logic        b_ext_i, b_ext_o;
  tag_t        b_tag_i, b_tag_o;
  aux_t        b_aux_i, b_aux_o;
  logic        b_iv, b_ir, b_fl, b_ov, b_or, b_busy;
  logic [1:0]  b_fill;

  fpnew_result_buffer #(.Width(32), .Depth(2), .TagType(tag_t), .AuxType(aux_t)) dut2 (
    .clk_i(clk), .rst_ni(rst_n),
    .result_i(a_res_i), .status_i(a_st_i), .extension_bit_i(a_ext_i), .tag_i(a_tag_i), .aux_i(a_aux_i),
    .in_valid_i(a_iv), .in_ready_o(a_ir), .flush_i(a_fl),
    .result_o(a_res_o), .status_o(a_st_o), .extension_bit_o(a_ext_o), .tag_o(a_tag_o), .aux_o(a_aux_o),
    .out_valid_o(a_ov), .out_ready_i(a_or), .fill_o(a_fill), .busy_o(a_busy)
  );

  fpnew_result_buffer #(.Width(32), .Depth(3), .TagType(tag_t), .AuxType(aux_t)) dut3 (
    .clk_i(clk), .rst_ni(rst_n),
    .result_i(b_res_i), .status_i(b_st_i), .extension_bit_i(b_ext_i), .tag_i(b_tag_i), .aux_i(b_aux_i),
    .in_valid_i(b_iv), .in_ready_o(b_ir), .flush_i(b_fl),
    .result_o(b_res_o), .status_o(b_st_o), .extension_bit_o(b_ext_o), .tag_o(b_tag_o), .aux_o(b_aux_o),
    .out_valid_o(b_ov), .out_ready_i(b_or), .fill_o(b_fill), .busy_o(b_busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model for the Depth=3 instance: a plain queue of accepted items.
  item_t bq[$];
  tag_t  b_out[$];
  logic  b_pushed, b_popped;

  // Inputs already driven; samples mid-cycle, then commits the model for the coming edge.
  task automatic b_step();
    item_t cur, head, act;
    logic  byp, eir, eov;
    cur = '{b_res_i, b_st_i, b_ext_i, b_tag_i, b_aux_i};
    #3;
    byp = 1'b0;
`ifdef FPNEW_RESULT_BUF_BYPASS_EN
    byp = (bq.size() == 0) && !b_fl && b_iv && b_or;
`endif
    eir = (bq.size() < 3) || b_fl;
    eov = ((bq.size() != 0) && !b_fl) || byp;
    chk("b_in_ready", 64'(b_ir), 64'(eir));
    chk("b_out_valid", 64'(b_ov), 64'(eov));
    chk("b_fill", 64'(b_fill), 64'(bq.size()));
    chk("b_busy", 64'(b_busy), 64'((bq.size() != 0) || b_iv));
    b_pushed = b_iv && eir && !b_fl;
    b_popped = eov && b_or;
    if (eov) begin
      head = byp ? cur : bq[0];
      act  = '{b_res_o, b_st_o, b_ext_o, b_tag_o, b_aux_o};
      chk("b_head", 64'(act), 64'(head));
      if (b_popped) b_out.push_back(head.tag);
    end
    if (b_fl) bq.delete();
    else if (!byp) begin
      if (b_popped) bq.delete(0);
      if (b_pushed) bq.push_back(cur);
    end
  endtask

  initial begin
    vec_t vt[12];
    int   sent;

    vt[0]  = '{1'b0, 32'h0, 5'h00, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 32'h0, 5'h00, 8'd0};
    vt[1]  = '{1'b1, 32'hA, 5'h01, 8'd1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 32'h0, 5'h00, 8'd0};
    vt[2]  = '{1'b1, 32'hB, 5'h10, 8'd2, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 32'hA, 5'h01, 8'd1};
    vt[3]  = '{1'b0, 32'h0, 5'h00, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 1'b1, 32'hA, 5'h01, 8'd1};
    vt[4]  = '{1'b1, 32'hD, 5'h00, 8'd4, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 1'b1, 32'hA, 5'h01, 8'd1};
    vt[5]  = '{1'b0, 32'h0, 5'h00, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 32'hB, 5'h10, 8'd2};
    vt[6]  = '{1'b0, 32'h0, 5'h00, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 32'h0, 5'h00, 8'd0};
    vt[7]  = '{1'b1, 32'hE, 5'h02, 8'd5, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 32'h0, 5'h00, 8'd0};
    vt[8]  = '{1'b1, 32'hF, 5'h04, 8'd6, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 32'hE, 5'h02, 8'd5};
    vt[9]  = '{1'b1, 32'hC, 5'h08, 8'd7, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 32'h0, 5'h00, 8'd0};
    vt[10] = '{1'b0, 32'h0, 5'h00, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 32'h0, 5'h00, 8'd0};
    vt[11] = '{1'b0, 32'h0, 5'h00, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 32'h0, 5'h00, 8'd0};

    a_res_i = '0; a_st_i = '0; a_ext_i = 1'b0; a_tag_i = '0; a_aux_i = '0;
    a_iv = 1'b0; a_fl = 1'b0; a_or = 1'b0;
    b_res_i = '0; b_st_i = '0; b_ext_i = 1'b0; b_tag_i = '0; b_aux_i = '0;
    b_iv = 1'b0; b_fl = 1'b0; b_or = 1'b0;

    // Reset values while reset is held
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(a_ov), 64'd0);
    chk("rst_in_ready", 64'(a_ir), 64'd1);
    chk("rst_fill", 64'(a_fill), 64'd0);
    chk("rst_busy", 64'(a_busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Depth=2 directed table: fill, full stall, drain in order, flush with concurrent input
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      a_iv = vt[i].iv; a_res_i = vt[i].res; a_st_i = vt[i].st; a_tag_i = vt[i].tag;
      a_or = vt[i].ordy; a_fl = vt[i].fl;
      #3;
      chk($sformatf("v%0d_out_valid", i), 64'(a_ov), 64'(vt[i].ov));
      chk($sformatf("v%0d_in_ready", i), 64'(a_ir), 64'(vt[i].ir));
      chk($sformatf("v%0d_fill", i), 64'(a_fill), 64'(vt[i].fill));
      chk($sformatf("v%0d_busy", i), 64'(a_busy), 64'(vt[i].busy));
      if (vt[i].ov) begin
        chk($sformatf("v%0d_result", i), 64'(a_res_o), 64'(vt[i].eres));
        chk($sformatf("v%0d_status", i), 64'(a_st_o), 64'(vt[i].est));
        chk($sformatf("v%0d_tag", i), 64'(a_tag_o), 64'(vt[i].etag));
      end
    end
    a_fl = 1'b0;

    // Latency on an empty buffer with a ready consumer
    @(posedge clk); #1;
    a_iv = 1'b1; a_res_i = 32'h3F800000; a_st_i = 5'h00; a_tag_i = 8'h33; a_or = 1'b1;
    #3;
`ifdef FPNEW_RESULT_BUF_BYPASS_EN
    chk("byp_out_valid", 64'(a_ov), 64'd1);
    chk("byp_result", 64'(a_res_o), 64'h3F800000);
`else
    chk("lat_out_valid_c0", 64'(a_ov), 64'd0);
`endif
    chk("lat_fill_c0", 64'(a_fill), 64'd0);
    @(posedge clk); #1;
    a_iv = 1'b0;
    #3;
`ifdef FPNEW_RESULT_BUF_BYPASS_EN
    chk("byp_out_valid_c1", 64'(a_ov), 64'd0);
    chk("byp_fill_c1", 64'(a_fill), 64'd0);
`else
    chk("lat_out_valid_c1", 64'(a_ov), 64'd1);
    chk("lat_result_c1", 64'(a_res_o), 64'h3F800000);
    chk("lat_fill_c1", 64'(a_fill), 64'd1);
`endif

    // Reset asserted while holding two entries
    @(posedge clk); #1;
    a_iv = 1'b1; a_res_i = 32'h11; a_or = 1'b0;
    @(posedge clk); #1;
    a_res_i = 32'h22;
    @(posedge clk); #1;
    a_iv = 1'b0;
    #1;
    chk("pre_rst_fill", 64'(a_fill), 64'd2);
    chk("pre_rst_out_valid", 64'(a_ov), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(a_ov), 64'd0);
    chk("mid_rst_fill", 64'(a_fill), 64'd0);
    chk("mid_rst_in_ready", 64'(a_ir), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    a_or = 1'b1;
    repeat (2) begin
      @(posedge clk); #4;
      chk("post_rst_out_valid", 64'(a_ov), 64'd0);
      chk("post_rst_fill", 64'(a_fill), 64'd0);
    end

    // Depth=3: ten back-to-back pushes with a toggling consumer
    sent = 0;
    b_out.delete();
    for (int c = 0; c < 80 && b_out.size() < 10; c++) begin
      @(posedge clk); #1;
      b_iv = (sent < 10);
      b_tag_i = 8'(sent);
      b_res_i = 32'h100 + 32'(sent);
      b_st_i = 5'(sent);
      b_aux_i = 4'(sent);
      b_or = c[0];
      b_step();
      if (b_pushed) sent++;
    end
    chk("order_count", 64'(b_out.size()), 64'd10);
    for (int i = 0; i < 10 && i < b_out.size(); i++)
      chk($sformatf("order_tag%0d", i), 64'(b_out[i]), 64'(i));

    // Randomized traffic with occasional flushes
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      b_iv    = ($urandom_range(0, 3) != 0);
      b_or    = $urandom_range(0, 1) == 1;
      b_fl    = ($urandom_range(0, 24) == 0);
      b_res_i = $urandom;
      b_st_i  = 5'($urandom);
      b_ext_i = $urandom_range(0, 1) == 1;
      b_tag_i = 8'($urandom);
      b_aux_i = 4'($urandom);
      b_step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
